ccl_loop_stack: RTL

CCL_LOOP_STACK -- requirements
Module: ccl_loop_stack

---
 rtl/ccl_pkg.sv | 23 ++
 rtl/ccl_ctx_stack.sv | 61 ++++++
 rtl/ccl_loop_stack.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ccl_pkg.sv
// Shared encodings and default sizing for the loop-stack block.
package ccl_pkg;

    typedef enum logic [1:0] {
        CMD_NOP     = 2'b00,
        CMD_BREAK   = 2'b01,
        CMD_LOOP    = 2'b10,
        CMD_ILLEGAL = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_ILLEGAL   = 2'd1,
        ERR_OVERFLOW  = 2'd2,
        ERR_UNDERFLOW = 2'd3
    } err_e;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_CNT_W   = 32;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_NUM_CTX = 4;

endpackage

// File: rtl/ccl_ctx_stack.sv
// One loop context: entry storage, level, and push/pop/decrement of the top.
module ccl_ctx_stack #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32,
    parameter int DEPTH  = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         dec,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [CNT_W-1:0]             push_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [$clog2(DEPTH+1)-1:0]   level_nxt,
    output logic [ADDR_W-1:0]            top_addr,
    output logic [CNT_W-1:0]             top_cnt
);

    localparam int LVL_W = $clog2(DEPTH+1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [CNT_W-1:0]  cnt_mem  [DEPTH];
    logic [LVL_W-1:0]  lvl_q;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  push_idx;

    // Top entry sits at level-1; the next free slot is at level.
    assign top_idx  = IDX_W'(lvl_q - LVL_W'(1));
    assign push_idx = IDX_W'(lvl_q);
    assign level    = lvl_q;
    assign top_addr = (lvl_q != '0) ? addr_mem[top_idx] : '0;
    assign top_cnt  = (lvl_q != '0) ? cnt_mem[top_idx]  : '0;

    // Next level: the caller guarantees push only when not full, pop only when not empty.
    always_comb begin
        level_nxt = lvl_q;
        if (push)     level_nxt = lvl_q + LVL_W'(1);
        else if (pop) level_nxt = lvl_q - LVL_W'(1);
    end

    // Level register; this alone defines which entries are live.
    always_ff @(posedge clock) begin
        if (reset) lvl_q <= '0;
        else       lvl_q <= level_nxt;
    end

    // Entry storage needs no reset: entries above the level are never read.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (push) begin
                addr_mem[push_idx] <= push_addr;
                cnt_mem[push_idx]  <= push_cnt;
            end else if (dec) begin
                cnt_mem[top_idx] <= cnt_mem[top_idx] - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ccl_loop_stack.sv
// Hardware loop stack: per-context loop tracking with a registered branch response.
module ccl_loop_stack
    import ccl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int NUM_CTX = DEF_NUM_CTX
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [((NUM_CTX > 1) ? $clog2(NUM_CTX) : 1)-1:0] ctx,
    input  logic [1:0]                                    command,
    input  logic [ADDR_W-1:0]                             address,
    input  logic [CNT_W-1:0]                              counter,
    input  logic [ADDR_W-1:0]                             in_target,
    output logic [ADDR_W-1:0]                             out_target,
    output logic                                          valid,
    output logic                                          error,
    output logic [1:0]                                    err_code,
    output logic [NUM_CTX-1:0]                            full,
    output logic [NUM_CTX-1:0]                            empty,
    output logic [$clog2(DEPTH+1)-1:0]                    level
);

    localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [NUM_CTX-1:0][LVL_W-1:0]  lvl_q;
    logic [NUM_CTX-1:0][LVL_W-1:0]  lvl_n;
    logic [NUM_CTX-1:0][ADDR_W-1:0] top_addr;
    logic [NUM_CTX-1:0][CNT_W-1:0]  top_cnt;
    logic [NUM_CTX-1:0]             push_v, pop_v, dec_v;
    logic [NUM_CTX-1:0]             full_nxt, empty_nxt;

    cmd_e              cmd;
    logic              ctx_ok;
    logic [CTX_W-1:0]  sel;
    logic [LVL_W-1:0]  lvl_sel;
    logic              hit;
    logic              nxt_valid;
    err_e              nxt_err;
    logic [ADDR_W-1:0] nxt_tgt;
    logic [LVL_W-1:0]  nxt_level;

    assign cmd     = cmd_e'(command);
    assign ctx_ok  = 32'(ctx) < NUM_CTX;
    assign sel     = ctx_ok ? ctx : '0;
    assign lvl_sel = lvl_q[sel];
    // Only the top entry is ever matched, on the full address width.
    assign hit     = (lvl_sel != '0) && (top_addr[sel] == address);

    // Decode the command against the selected context's top entry.
    always_comb begin
        push_v    = '0;
        pop_v     = '0;
        dec_v     = '0;
        nxt_valid = 1'b0;
        nxt_err   = ERR_NONE;
        nxt_tgt   = '0;
        if (!reset) begin
            if (!ctx_ok || cmd == CMD_ILLEGAL) begin
                nxt_err = ERR_ILLEGAL;
            end else begin
                case (cmd)
                    CMD_LOOP: begin
                        if (hit) begin
                            if (top_cnt[sel] > CNT_W'(1)) begin
                                dec_v[sel] = 1'b1;
                                nxt_valid  = 1'b1;
                                nxt_tgt    = in_target;
                            end else begin
                                // Last iteration: fall through and retire the loop.
                                pop_v[sel] = 1'b1;
                            end
                        end else if (counter == '0) begin
                            nxt_err = ERR_UNDERFLOW;
                        end else if (counter == CNT_W'(1)) begin
                            // Single-pass loop never branches back; nothing to track.
                        end else if (lvl_sel == LVL_W'(DEPTH)) begin
                            nxt_err = ERR_OVERFLOW;
                        end else begin
                            push_v[sel] = 1'b1;
                            nxt_valid   = 1'b1;
                            nxt_tgt     = in_target;
                        end
                    end
                    CMD_BREAK: begin
                        if (lvl_sel == '0) begin
                            nxt_err = ERR_UNDERFLOW;
                        end else begin
                            pop_v[sel] = 1'b1;
                            nxt_valid  = 1'b1;
                            nxt_tgt    = in_target;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // One stack per context; flags are computed from each context's next level.
    for (genvar i = 0; i < NUM_CTX; i++) begin : g_ctx
        ccl_ctx_stack #(
            .ADDR_W (ADDR_W),
            .CNT_W  (CNT_W),
            .DEPTH  (DEPTH)
        ) u_stack (
            .clock     (clock),
            .reset     (reset),
            .push      (push_v[i]),
            .pop       (pop_v[i]),
            .dec       (dec_v[i]),
            .push_addr (address),
            .push_cnt  (counter - CNT_W'(1)),
            .level     (lvl_q[i]),
            .level_nxt (lvl_n[i]),
            .top_addr  (top_addr[i]),
            .top_cnt   (top_cnt[i])
        );
        assign full_nxt[i]  = lvl_n[i] == LVL_W'(DEPTH);
        assign empty_nxt[i] = lvl_n[i] == '0;
    end

    assign nxt_level = ctx_ok ? lvl_n[sel] : '0;

    // Register the response so it appears exactly one cycle after the command.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid      <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
            out_target <= '0;
            level      <= '0;
            full       <= '0;
            empty      <= '1;
        end else begin
            valid      <= nxt_valid;
            error      <= (nxt_err != ERR_NONE);
            err_code   <= nxt_err;
            out_target <= nxt_tgt;
            level      <= nxt_level;
            full       <= full_nxt;
            empty      <= empty_nxt;
        end
    end

endmodule
